// File: rtl/b2d_seq_disp.sv
// Sequential binary-to-decimal seven-segment driver using a one-bit-per-clock double-dabble engine.
// Define B2D_SEQ_BLANK_EN to blank leading zeros above digit 0.
//
// state | meaning
// IDLE  | ready for a new value, display holds last result
// CONV  | shift-and-add-3, one input bit per clock
// LOAD  | new HEX/ovf visible, done pulse
module b2d_seq_disp #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  RST,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [WIDTH-1:0]      shift_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_sh;
    logic                  ovf_sticky_q;
    logic                  ovf_sh;
    logic [CW-1:0]         cnt_q;
    logic [DIGITS-1:0]     blank;
    logic [7*DIGITS-1:0]   hex_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // A one leaving the top nibble means the value needs more than DIGITS digits.
    assign bcd_sh = {bcd_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
    assign ovf_sh = ovf_sticky_q | bcd_adj[4*DIGITS-1];

    always_comb begin : p_blank
        logic seen_nz;
        seen_nz = 1'b0;
        blank   = '0;
`ifdef B2D_SEQ_BLANK_EN
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_sh[4*i +: 4] != 4'd0)
                seen_nz = 1'b1;
            blank[i] = !seen_nz && (i != 0);
        end
`endif
    end

    always_comb begin
        hex_nx = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_sh)
                hex_nx[7*i +: 7] = SEG_E;
            else if (blank[i])
                hex_nx[7*i +: 7] = SEG_BLANK;
            else
                hex_nx[7*i +: 7] = seg7(bcd_sh[4*i +: 4]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CONV;
            CONV:    if (cnt_q == CW'(1)) state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Display registers update on the final shift edge so HEX, ovf and done
    // are all presented together during the LOAD cycle.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state        <= IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            ovf_sticky_q <= 1'b0;
            cnt_q        <= '0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            HEX          <= '1;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_q      <= in_value;
                        bcd_q        <= '0;
                        ovf_sticky_q <= 1'b0;
                        cnt_q        <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    shift_q      <= {shift_q[WIDTH-2:0], 1'b0};
                    bcd_q        <= bcd_sh;
                    ovf_sticky_q <= ovf_sh;
                    cnt_q        <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        HEX  <= hex_nx;
                        ovf  <= ovf_sh;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
